// File: rtl/ysyx_22040383_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encodings are fixed because other pipeline blocks decode them.
package ysyx_22040383_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } hz_state_t;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    function automatic logic is_x0(input logic [REG_IDX_W-1:0] idx);
        return idx == REG_X0;
    endfunction

endpackage

// File: rtl/ysyx_22040383_hazard_ctrl_if.sv
// Bundle of pipeline-status inputs and stage-control outputs around the hazard controller.
// master = the controller itself, slave = the pipeline/dmem side.
interface ysyx_22040383_hazard_ctrl_if
    import ysyx_22040383_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_is_write_rf;
    logic                 ex_is_load;
    logic                 ex_redirect;
    logic                 mem_access;
    logic                 dmem_ready;

    logic                 dmem_req_valid;
    logic                 pc_hold;
    logic                 ifid_hold;
    logic                 ifid_flush;
    logic                 idex_hold;
    logic                 idex_flush;
    logic                 exmem_hold;
    logic                 memwb_bubble;
    logic                 mem_timeout_err;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_is_write_rf, ex_is_load, ex_redirect,
        input  mem_access, dmem_ready,
        output dmem_req_valid, pc_hold, ifid_hold, ifid_flush,
        output idex_hold, idex_flush, exmem_hold, memwb_bubble,
        output mem_timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_is_write_rf, ex_is_load, ex_redirect,
        output mem_access, dmem_ready,
        input  dmem_req_valid, pc_hold, ifid_hold, ifid_flush,
        input  idex_hold, idex_flush, exmem_hold, memwb_bubble,
        input  mem_timeout_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/ysyx_22040383_hazard_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load still sitting in EX.
module ysyx_22040383_hazard_detect
    import ysyx_22040383_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_is_write_rf,
    input  logic                 ex_is_load,
    output logic                 load_use
);
    logic [REG_IDX_W-1:0] src [2];
    logic [1:0]           src_used;
    logic [1:0]           src_hit;

    assign src[0]      = id_rs1;
    assign src[1]      = id_rs2;
    assign src_used[0] = id_uses_rs1;
    assign src_used[1] = id_uses_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] & (src[gi] == ex_rd);
        end
    endgenerate

    // x0 never carries a real value, so a load into it never creates a dependency
    assign load_use = ex_is_load & ex_is_write_rf & ~is_x0(ex_rd) & (|src_hit);

endmodule

// File: rtl/ysyx_22040383_hazard_ctrl.sv
// Five-stage pipeline controller: hold/flush/bubble enables from load-use,
// EX redirects and a time-bounded dmem handshake, plus stall/flush counters.
module ysyx_22040383_hazard_ctrl
    import ysyx_22040383_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
)(
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    ysyx_22040383_hazard_ctrl_if.master hz
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    hz_state_t         state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              err_reg, err_next;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  flush_cnt_reg;

    logic load_use;
    logic mem_stall;
    logic redirect_flush;

    ysyx_22040383_hazard_detect u_detect (
        .id_rs1         (hz.id_rs1),
        .id_rs2         (hz.id_rs2),
        .id_uses_rs1    (hz.id_uses_rs1),
        .id_uses_rs2    (hz.id_uses_rs2),
        .ex_rd          (hz.ex_rd),
        .ex_is_write_rf (hz.ex_is_write_rf),
        .ex_is_load     (hz.ex_is_load),
        .load_use       (load_use)
    );

    assign mem_stall = hz.mem_access & ~hz.dmem_ready & (state_reg != ST_ERROR);

    // Control outputs act in the same cycle; reset forces NOPs into the pipe
    always_comb begin
        hz.dmem_req_valid = 1'b0;
        hz.pc_hold        = 1'b0;
        hz.ifid_hold      = 1'b0;
        hz.ifid_flush     = 1'b0;
        hz.idex_hold      = 1'b0;
        hz.idex_flush     = 1'b0;
        hz.exmem_hold     = 1'b0;
        hz.memwb_bubble   = 1'b0;
        redirect_flush    = 1'b0;
        if (!sys_rst) begin
            hz.ifid_flush   = 1'b1;
            hz.idex_flush   = 1'b1;
            hz.memwb_bubble = 1'b1;
        end else if (state_reg == ST_ERROR) begin
            hz.pc_hold      = 1'b1;
            hz.ifid_hold    = 1'b1;
            hz.idex_hold    = 1'b1;
            hz.exmem_hold   = 1'b1;
            hz.memwb_bubble = 1'b1;
        end else begin
            hz.dmem_req_valid = hz.mem_access;
            if (mem_stall) begin
                hz.pc_hold      = 1'b1;
                hz.ifid_hold    = 1'b1;
                hz.idex_hold    = 1'b1;
                hz.exmem_hold   = 1'b1;
                hz.memwb_bubble = 1'b1;
            end else if (hz.ex_redirect) begin
                hz.ifid_flush  = 1'b1;
                hz.idex_flush  = 1'b1;
                redirect_flush = 1'b1;
            end else if (load_use) begin
                hz.pc_hold    = 1'b1;
                hz.ifid_hold  = 1'b1;
                hz.idex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        err_next      = err_reg;
        case (state_reg)
            ST_RUN: begin
                if (mem_stall) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                // a dropped mem_access is tolerated and simply ends the wait
                if (!mem_stall) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT)) begin
                    state_next = ST_ERROR;
                    err_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            default: begin
                state_next = ST_ERROR;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            err_reg       <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
            if (hz.pc_hold) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (redirect_flush) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign hz.mem_timeout_err = err_reg;
    assign hz.stall_cnt       = stall_cnt_reg;
    assign hz.flush_cnt       = flush_cnt_reg;

endmodule

// File: tb/tb_ysyx_22040383_hazard_ctrl.sv
// Scoreboard bench: directed scenarios plus randomized traffic checked against
// a cycle-level reference model of the hazard rules.
module tb_ysyx_22040383_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 8;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wrf;
        logic       ld;
        logic       redir;
        logic       macc;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        logic [7:0]       ctrl;
        logic             err;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst;
    always #5 sys_clk = ~sys_clk;

    ysyx_22040383_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    ysyx_22040383_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .hz      (hz)
    );

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    // reference model state: consecutive stalled cycles, sticky error, counters
    int               m_streak = 0;
    bit               m_err    = 0;
    logic [CNT_W-1:0] m_stall  = '0;
    logic [CNT_W-1:0] m_flush  = '0;
    stim_t            cur;

    function automatic bit ref_load_use(input stim_t s);
        logic [4:0] src [2];
        bit         used [2];
        bit         hit = 0;
        src[0] = s.rs1; src[1] = s.rs2;
        used[0] = s.u1; used[1] = s.u2;
        for (int i = 0; i < 2; i++)
            if (used[i] && src[i] == s.rd) hit = 1;
        return s.ld && s.wrf && (s.rd != 0) && hit;
    endfunction

    // ctrl bit order: req, pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_bubble
    function automatic exp_t ref_outputs(input stim_t s);
        exp_t e;
        bit   ms;
        e.ctrl  = 8'b0;
        e.err   = m_err;
        e.stall = m_stall;
        e.flush = m_flush;
        ms = s.macc && !s.rdy;
        if (!s.rst)          e.ctrl = 8'b0001_0101;
        else if (m_err)      e.ctrl = 8'b0110_1011;
        else if (ms)         e.ctrl = 8'b1110_1011;
        else if (s.redir)    e.ctrl = {s.macc, 7'b001_0100};
        else if (ref_load_use(s)) e.ctrl = {s.macc, 7'b110_0100};
        else                 e.ctrl = {s.macc, 7'b0};
        return e;
    endfunction

    task automatic ref_clock(input stim_t s);
        bit ms;
        ms = s.macc && !s.rdy;
        if (!s.rst) begin
            m_streak = 0; m_err = 0; m_stall = '0; m_flush = '0;
        end else if (m_err) begin
            m_stall = m_stall + CNT_W'(1);
        end else begin
            if (ms || (ref_load_use(s) && !s.redir)) m_stall = m_stall + CNT_W'(1);
            if (!ms && s.redir) m_flush = m_flush + CNT_W'(1);
            m_streak = ms ? m_streak + 1 : 0;
            if (m_streak > TIMEOUT) m_err = 1;
        end
    endtask

    task automatic apply(input stim_t s);
        sys_rst           = s.rst;
        hz.id_rs1         = s.rs1;
        hz.id_rs2         = s.rs2;
        hz.id_uses_rs1    = s.u1;
        hz.id_uses_rs2    = s.u2;
        hz.ex_rd          = s.rd;
        hz.ex_is_write_rf = s.wrf;
        hz.ex_is_load     = s.ld;
        hz.ex_redirect    = s.redir;
        hz.mem_access     = s.macc;
        hz.dmem_ready     = s.rdy;
    endtask

    task automatic step(input stim_t s);
        @(posedge sys_clk);
        #1;
        ref_clock(cur);
        cur = s;
        apply(s);
        sb_q.push_back(ref_outputs(s));
    endtask

    function automatic stim_t mk(input bit rst, input bit ld, input logic [4:0] rd,
                                 input logic [4:0] rs1, input bit redir,
                                 input bit macc, input bit rdy);
        stim_t s;
        s = '0;
        s.rst = rst; s.ld = ld; s.wrf = ld; s.rd = rd; s.rs1 = rs1; s.u1 = 1'b1;
        s.rs2 = 5'd1; s.u2 = 1'b1; s.redir = redir; s.macc = macc; s.rdy = rdy;
        return s;
    endfunction

    function automatic stim_t rnd(input bit macc, input bit rdy);
        stim_t s;
        s.rst   = ($urandom_range(0, 63) != 0);
        s.rs1   = 5'($urandom_range(0, 3));
        s.rs2   = 5'($urandom_range(0, 3));
        s.u1    = 1'($urandom_range(0, 1));
        s.u2    = 1'($urandom_range(0, 1));
        s.rd    = 5'($urandom_range(0, 3));
        s.wrf   = 1'($urandom_range(0, 1));
        s.ld    = 1'($urandom_range(0, 1));
        s.redir = ($urandom_range(0, 5) == 0);
        s.macc  = macc;
        s.rdy   = rdy;
        return s;
    endfunction

    // monitor: one scoreboard entry per cycle, compared mid-cycle
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge sys_clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {hz.dmem_req_valid, hz.pc_hold, hz.ifid_hold, hz.ifid_flush,
                       hz.idex_hold, hz.idex_flush, hz.exmem_hold, hz.memwb_bubble};
                n_checks += 4;
                if (act !== e.ctrl) begin
                    n_errors++;
                    $display("FAIL ctrl t=%0t got %b expected %b", $time, act, e.ctrl);
                end
                if (hz.mem_timeout_err !== e.err) begin
                    n_errors++;
                    $display("FAIL timeout_err t=%0t got %b expected %b", $time, hz.mem_timeout_err, e.err);
                end
                if (hz.stall_cnt !== e.stall) begin
                    n_errors++;
                    $display("FAIL stall_cnt t=%0t got %0d expected %0d", $time, hz.stall_cnt, e.stall);
                end
                if (hz.flush_cnt !== e.flush) begin
                    n_errors++;
                    $display("FAIL flush_cnt t=%0t got %0d expected %0d", $time, hz.flush_cnt, e.flush);
                end
                $display("txn t=%0t ctrl=%b err=%b stall=%0d flush=%0d", $time, act,
                         hz.mem_timeout_err, hz.stall_cnt, hz.flush_cnt);
            end
        end
    end

    initial begin
        int wait_len;
        cur = mk(0, 0, 0, 0, 0, 0, 0);
        apply(cur);
        // reset
        step(mk(0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0));
        // load-use on x5, then the same with x0 as destination
        step(mk(1, 1, 5, 5, 0, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0));
        step(mk(1, 1, 0, 0, 0, 0, 0));
        // redirect coinciding with load-use
        step(mk(1, 1, 5, 5, 1, 0, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0));
        // three-cycle wait, then zero-wait access
        for (int i = 0; i < 3; i++) step(mk(1, 0, 0, 0, 0, 1, 0));
        step(mk(1, 0, 0, 0, 0, 1, 1));
        step(mk(1, 0, 0, 0, 0, 1, 1));
        step(mk(1, 0, 0, 0, 0, 0, 0));
        // memory stall with pending redirect
        for (int i = 0; i < 2; i++) step(mk(1, 0, 0, 0, 1, 1, 0));
        step(mk(1, 0, 0, 0, 1, 1, 1));
        step(mk(1, 0, 0, 0, 1, 0, 0));
        // timeout into ERROR, linger long enough to wrap stall_cnt, then reset
        for (int i = 0; i < 300; i++) step(mk(1, 0, 0, 0, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 1, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0));
        // reset in the second wait cycle, held two cycles
        step(mk(1, 0, 0, 0, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 1, 0));
        step(mk(0, 0, 0, 0, 0, 1, 0));
        step(mk(1, 0, 0, 0, 0, 0, 0));
        // randomized traffic: idle/random cycles, then an access with random wait length
        for (int t = 0; t < 200; t++) begin
            for (int k = 0; k < $urandom_range(0, 2); k++) step(rnd($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1))));
            wait_len = $urandom_range(0, TIMEOUT + 3);
            for (int k = 0; k < wait_len; k++) step(rnd(1'b1, 1'b0));
            step(rnd(1'b1, 1'b1));
        end
        @(negedge sys_clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain left %0d expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
